mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_burst_counter.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the single-port memory arbiter.
//   arb_state_e          : response FSM state (what read, if any, is outstanding)
//   ARB_MAX_DATA_BURST   : default cap on consecutive data grants while fetch waits
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,  // no read outstanding
      RESP_IF = 2'd1,  // fetch read outstanding, data returns this cycle
      RESP_DM = 2'd2   // data read outstanding, data returns this cycle
   } arb_state_e;

   localparam int ARB_MAX_DATA_BURST = 4;

endpackage : arb_pkg

// File: rtl/arb_burst_counter.sv
// Saturating count of data grants made while fetch is waiting. Once the count
// reaches MAX_COUNT the arbiter lets fetch win over a simultaneous data request.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   i_if_req     : fetch is requesting this cycle
//   i_dm_grant   : data access granted this cycle
//   i_if_grant   : fetch access granted this cycle
//   o_cnt        : current count (registered)
//   o_sat        : count has reached MAX_COUNT
module arb_burst_counter #(
   parameter int MAX_COUNT = 4,
   parameter int CW        = $clog2(MAX_COUNT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_if_req,
   input  logic          i_dm_grant,
   input  logic          i_if_grant,
   output logic [CW-1:0] o_cnt,
   output logic          o_sat
);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   assign o_cnt = r_cnt;
   assign o_sat = (r_cnt == CW'(MAX_COUNT));

   always_comb begin
      w_cnt_nxt = r_cnt;
      // Fetch no longer waiting (served or gone) starts a fresh burst window.
      if (!i_if_req || i_if_grant) begin
         w_cnt_nxt = '0;
      end else if (i_dm_grant && !o_sat) begin
         w_cnt_nxt = r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule : arb_burst_counter

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch stage and the
// memory stage of a pipeline. Arbitration is combinational in the request
// cycle; read data comes back exactly one cycle after the grant and is routed
// to whoever was granted, while a new grant may be made in that same cycle.
//
// Handshake (both requesters): a requester raises req with addr/data and keeps
// them stable; the access is accepted in the first cycle where req=1 and
// stall=0. stall is only ever 1 while req=1. Nothing is latched here, so the
// requester must hold its request until accepted. In the pipeline, if_stall is
// ORed into the PC/IF-ID enable path and dm_stall stalls every stage up to
// EX/MEM.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   if_req, if_addr                  : fetch read request
//   if_rdata, if_valid, if_stall     : fetch response / stall
//   dm_req, dm_we, dm_addr, dm_wdata : data access request
//   dm_rdata, dm_valid, dm_stall     : data response / stall
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata             : single-port memory interface
//   o_dbg_state, o_dbg_burst_cnt     : observability of FSM state and burst count
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int MAX_DATA_BURST = ARB_MAX_DATA_BURST
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  if_req,
   input  logic [ADDRESS_WIDTH-1:0]              if_addr,
   output logic [DATA_WIDTH-1:0]                 if_rdata,
   output logic                                  if_valid,
   output logic                                  if_stall,
   input  logic                                  dm_req,
   input  logic                                  dm_we,
   input  logic [ADDRESS_WIDTH-1:0]              dm_addr,
   input  logic [DATA_WIDTH-1:0]                 dm_wdata,
   output logic [DATA_WIDTH-1:0]                 dm_rdata,
   output logic                                  dm_valid,
   output logic                                  dm_stall,
   output logic                                  mem_en,
   output logic                                  mem_we,
   output logic [ADDRESS_WIDTH-1:0]              mem_addr,
   output logic [DATA_WIDTH-1:0]                 mem_wdata,
   input  logic [DATA_WIDTH-1:0]                 mem_rdata,
   output arb_state_e                            o_dbg_state,
   output logic [$clog2(MAX_DATA_BURST+1)-1:0]   o_dbg_burst_cnt
);

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   logic       w_if_grant;
   logic       w_dm_grant;
   logic       w_burst_sat;

   arb_burst_counter #(
      .MAX_COUNT (MAX_DATA_BURST)
   ) u_burst_counter (
      .clk        (clk),
      .rst        (rst),
      .i_if_req   (if_req),
      .i_dm_grant (w_dm_grant),
      .i_if_grant (w_if_grant),
      .o_cnt      (o_dbg_burst_cnt),
      .o_sat      (w_burst_sat)
   );

   assign o_dbg_state = r_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_if_grant  = 1'b0;
      w_dm_grant  = 1'b0;
      w_state_nxt = IDLE;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;

      // Data normally wins; fetch wins once data has had a full burst.
      w_if_grant = if_req && (!dm_req || w_burst_sat);
      w_dm_grant = dm_req && !w_if_grant;

      if (w_if_grant) begin
         mem_en      = 1'b1;
         mem_addr    = if_addr;
         w_state_nxt = RESP_IF;
      end else if (w_dm_grant) begin
         mem_en      = 1'b1;
         mem_we      = dm_we;
         mem_addr    = dm_addr;
         mem_wdata   = dm_wdata;
         // A write finishes in its grant cycle; only reads leave a response pending.
         w_state_nxt = dm_we ? IDLE : RESP_DM;
      end

      if_stall = if_req && !w_if_grant;
      dm_stall = dm_req && !w_dm_grant;

      // Valids follow the registered state so reset clears them immediately.
      if_valid = (r_state == RESP_IF);
      dm_valid = (r_state == RESP_DM);
      if_rdata = mem_rdata;
      dm_rdata = mem_rdata;
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1 ns after the rising
// edge, outputs are sampled 2 ns after it; expected values are hand-derived.
module tb_mem_port_arbiter;
   import arb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          if_stall;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_valid;
   logic          dm_stall;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   arb_state_e    dbg_state;
   logic [2:0]    dbg_burst_cnt;

   int n_total = 0;
   int n_bad   = 0;

   mem_port_arbiter #(
      .DATA_WIDTH     (DW),
      .ADDRESS_WIDTH  (AW),
      .MAX_DATA_BURST (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .if_req          (if_req),
      .if_addr         (if_addr),
      .if_rdata        (if_rdata),
      .if_valid        (if_valid),
      .if_stall        (if_stall),
      .dm_req          (dm_req),
      .dm_we           (dm_we),
      .dm_addr         (dm_addr),
      .dm_wdata        (dm_wdata),
      .dm_rdata        (dm_rdata),
      .dm_valid        (dm_valid),
      .dm_stall        (dm_stall),
      .mem_en          (mem_en),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .o_dbg_state     (dbg_state),
      .o_dbg_burst_cnt (dbg_burst_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_idle();
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_mem_en"},   mem_en,   0);
      chk({tag, "_mem_we"},   mem_we,   0);
      chk({tag, "_if_stall"}, if_stall, 0);
      chk({tag, "_dm_stall"}, dm_stall, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n_dm_writes;
      rst       = 1'b0;
      mem_rdata = '0;
      drive_idle();

      // Reset state
      next_cycle();
      next_cycle();
      settle();
      chk("rst_if_valid", if_valid, 0);
      chk("rst_dm_valid", dm_valid, 0);
      chk("rst_state", dbg_state, IDLE);
      chk("rst_burst", dbg_burst_cnt, 0);
      chk_quiet("rst");

      // Fetch alone; first grant in the first cycle after release
      next_cycle();
      rst     = 1'b1;
      if_req  = 1'b1;
      if_addr = 32'h10;
      settle();
      chk("f1_mem_en", mem_en, 1);
      chk("f1_mem_addr", mem_addr, 32'h10);
      chk("f1_mem_we", mem_we, 0);
      chk("f1_if_stall", if_stall, 0);
      next_cycle();
      drive_idle();
      mem_rdata = 32'h00500093;
      settle();
      chk("f1_if_valid", if_valid, 1);
      chk("f1_if_rdata", if_rdata, 32'h00500093);
      chk("f1_dm_valid", dm_valid, 0);
      chk("f1_if_stall_c1", if_stall, 0);
      next_cycle();
      settle();
      chk("f1_if_valid_c2", if_valid, 0);
      chk_quiet("f1_idle");
      chk("f1_burst", dbg_burst_cnt, 0);

      // Fetch and data read together: data first, fetch next cycle
      next_cycle();
      if_req  = 1'b1;
      if_addr = 32'h20;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h100;
      settle();
      chk("c2_mem_en", mem_en, 1);
      chk("c2_mem_addr", mem_addr, 32'h100);
      chk("c2_mem_we", mem_we, 0);
      chk("c2_if_stall", if_stall, 1);
      chk("c2_dm_stall", dm_stall, 0);
      next_cycle();
      dm_req    = 1'b0;
      mem_rdata = 32'hCAFE0001;
      settle();
      chk("c2_dm_valid", dm_valid, 1);
      chk("c2_dm_rdata", dm_rdata, 32'hCAFE0001);
      chk("c2_if_valid", if_valid, 0);
      chk("c2_fetch_addr", mem_addr, 32'h20);
      chk("c2_if_stall_c1", if_stall, 0);
      chk("c2_burst_c1", dbg_burst_cnt, 1);
      next_cycle();
      drive_idle();
      mem_rdata = 32'h11112222;
      settle();
      chk("c2_if_valid_c2", if_valid, 1);
      chk("c2_if_rdata", if_rdata, 32'h11112222);
      chk("c2_dm_valid_c2", dm_valid, 0);
      chk("c2_burst_c2", dbg_burst_cnt, 0);

      // Data writes held 6 cycles against a waiting fetch
      n_dm_writes = 0;
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         if_req    = 1'b1;
         if_addr   = 32'h40;
         dm_req    = 1'b1;
         dm_we     = 1'b1;
         dm_addr   = 32'h200;
         dm_wdata  = 32'hDEADBEEF;
         mem_rdata = 32'h0BADF00D;
         settle();
         chk($sformatf("bw%0d_mem_en", i), mem_en, 1);
         chk($sformatf("bw%0d_mem_we", i), mem_we, (i != 4));
         chk($sformatf("bw%0d_mem_addr", i), mem_addr, (i != 4) ? 32'h200 : 32'h40);
         chk($sformatf("bw%0d_if_stall", i), if_stall, (i != 4));
         chk($sformatf("bw%0d_dm_stall", i), dm_stall, (i == 4));
         chk($sformatf("bw%0d_burst", i), dbg_burst_cnt, (i == 5) ? 0 : i);
         chk($sformatf("bw%0d_dm_valid", i), dm_valid, 0);
         chk($sformatf("bw%0d_if_valid", i), if_valid, (i == 5));
         if (i != 4) chk($sformatf("bw%0d_mem_wdata", i), mem_wdata, 32'hDEADBEEF);
         if (i == 5) chk("bw5_if_rdata", if_rdata, 32'h0BADF00D);
         if (i < 5 && mem_en && mem_we) n_dm_writes++;
      end
      chk("bw_data_grants", n_dm_writes, 4);
      next_cycle();
      drive_idle();
      settle();
      chk("bw_tail_dm_valid", dm_valid, 0);
      chk("bw_tail_if_valid", if_valid, 0);
      chk_quiet("bw_tail");
      next_cycle();
      settle();
      chk("idle_burst", dbg_burst_cnt, 0);
      chk_quiet("idle");

      // Alternating fetch / data reads every cycle
      for (int k = 0; k < 7; k++) begin
         next_cycle();
         if_req    = (k < 6) && (k % 2 == 0);
         dm_req    = (k < 6) && (k % 2 == 1);
         dm_we     = 1'b0;
         if_addr   = 32'h1000 + 32'(k * 4);
         dm_addr   = 32'h2000 + 32'(k * 4);
         mem_rdata = 32'hA0000000 + 32'(k);
         settle();
         if (k < 6) begin
            chk($sformatf("alt%0d_mem_en", k), mem_en, 1);
            chk($sformatf("alt%0d_mem_addr", k), mem_addr,
                (k % 2 == 0) ? 32'h1000 + 32'(k * 4) : 32'h2000 + 32'(k * 4));
         end
         if (k == 0) begin
            chk("alt0_if_valid", if_valid, 0);
            chk("alt0_dm_valid", dm_valid, 0);
         end else begin
            chk($sformatf("alt%0d_if_valid", k), if_valid, ((k - 1) % 2 == 0));
            chk($sformatf("alt%0d_dm_valid", k), dm_valid, ((k - 1) % 2 == 1));
            if ((k - 1) % 2 == 0)
               chk($sformatf("alt%0d_if_rdata", k), if_rdata, 32'hA0000000 + 32'(k));
            else
               chk($sformatf("alt%0d_dm_rdata", k), dm_rdata, 32'hA0000000 + 32'(k));
         end
      end

      // Reset asserted mid-cycle while a data read is being returned
      next_cycle();
      if_req  = 1'b1;
      if_addr = 32'h300;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h400;
      settle();
      chk("mr_mem_addr", mem_addr, 32'h400);
      next_cycle();
      drive_idle();
      mem_rdata = 32'h5555AAAA;
      settle();
      chk("mr_dm_valid_pre", dm_valid, 1);
      chk("mr_dm_rdata_pre", dm_rdata, 32'h5555AAAA);
      chk("mr_burst_pre", dbg_burst_cnt, 1);
      #1;
      rst = 1'b0;
      #1;
      chk("mr_dm_valid_async", dm_valid, 0);
      chk("mr_state_async", dbg_state, IDLE);
      chk("mr_burst_async", dbg_burst_cnt, 0);
      next_cycle();
      rst = 1'b1;
      settle();
      chk("mr_rel1_dm_valid", dm_valid, 0);
      chk("mr_rel1_if_valid", if_valid, 0);
      next_cycle();
      settle();
      chk("mr_rel2_dm_valid", dm_valid, 0);
      chk("mr_rel2_if_valid", if_valid, 0);
      chk_quiet("mr_rel2");

      // Traffic resumes normally after the reset
      next_cycle();
      if_req  = 1'b1;
      if_addr = 32'h500;
      settle();
      chk("post_mem_en", mem_en, 1);
      chk("post_mem_addr", mem_addr, 32'h500);
      next_cycle();
      drive_idle();
      mem_rdata = 32'h13579BDF;
      settle();
      chk("post_if_valid", if_valid, 1);
      chk("post_if_rdata", if_rdata, 32'h13579BDF);

      next_cycle();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_mem_port_arbiter
